axil_selftest_master: RTL and testbench

AXIL_SELFTEST_MASTER -- requirements
Module: axil_selftest_master

---
 rtl/axil_selftest_pkg.sv | 22 ++
 rtl/axil_selftest_pattern.sv | 32 +++
 rtl/axil_selftest_master.sv | 195 +++++++++++++++++++
 tb/tb_axil_selftest_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axil_selftest_pkg.sv
// Shared types for the AXI4-Lite write/read-back self-test master.
package axil_selftest_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_INV   = 2'd2,
        MODE_INCR2 = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD,
        ST_RD_RESP,
        ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_selftest_pattern.sv
// Combinational test pattern P(i) from mode, seed and word index.
module axil_selftest_pattern
    import axil_selftest_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IW     = 2
) (
    input  mode_e              mode_i,
    input  logic [DATA_W-1:0]  seed_i,
    input  logic [IW-1:0]      idx_i,
    output logic [DATA_W-1:0]  pat_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sum;
    logic [31:0]       idx32;
    logic [SH_W-1:0]   sh;

    // DATA_W is a power of two, so i mod DATA_W is just the low index bits.
    assign idx32 = 32'(idx_i);
    assign sh    = idx32[SH_W-1:0];
    assign sum   = seed_i + DATA_W'(idx_i);

    always_comb begin
        case (mode_i)
            MODE_WALK: pat_o = {{(DATA_W-1){1'b0}}, 1'b1} << sh;
            MODE_INV:  pat_o = ~sum;
            default:   pat_o = sum;
        endcase
    end

endmodule

// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master: writes NUM_WORDS pattern words, reads them back and counts failures.
module axil_selftest_master
    import axil_selftest_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_WORDS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    localparam int               CW        = $clog2(NUM_WORDS + 1),
    localparam int               IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CW-1:0]        err_cnt,
    output logic [IW-1:0]        first_err_idx,
    output logic [ADDR_W-1:0]    m_axi_awaddr,
    output logic [2:0]           m_axi_awprot,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [DATA_W-1:0]    m_axi_wdata,
    output logic [DATA_W/8-1:0]  m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_W-1:0]    m_axi_araddr,
    output logic [2:0]           m_axi_arprot,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [DATA_W-1:0]    m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);
    state_e                state_q;
    mode_e                 mode_q;
    logic [DATA_W-1:0]     seed_q;
    logic [IW-1:0]         idx_q;
    logic                  sent_q;
    logic [NUM_WORDS-1:0]  wr_err_q;
    logic                  busy_q, done_q, pass_q;
    logic [CW-1:0]         err_cnt_q;
    logic [IW-1:0]         first_err_q;
    logic [ADDR_W-1:0]     awaddr_q, araddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

    logic [DATA_W-1:0]     pat;
    logic [ADDR_W-1:0]     word_addr;
    logic                  last_word, wr_fail, rd_fail, new_err;

    axil_selftest_pattern #(.DATA_W(DATA_W), .IW(IW)) u_pattern (
        .mode_i (mode_q),
        .seed_i (seed_q),
        .idx_i  (idx_q),
        .pat_o  (pat)
    );

    assign word_addr = BASE_ADDR + (ADDR_W'(idx_q) << $clog2(DATA_W / 8));
    assign last_word = (idx_q == IW'(NUM_WORDS - 1));
    assign wr_fail   = (m_axi_bresp != RESP_OKAY);
    // A word already failed on its write is not counted again on read-back.
    assign rd_fail   = ((m_axi_rresp != RESP_OKAY) || (m_axi_rdata != pat)) && !wr_err_q[idx_q];
    assign new_err   = (state_q == ST_WR_RESP && m_axi_bvalid && wr_fail) ||
                       (state_q == ST_RD_RESP && m_axi_rvalid && rd_fail);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_INCR;
            seed_q      <= '0;
            idx_q       <= '0;
            sent_q      <= 1'b0;
            wr_err_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            if (new_err) begin
                if (err_cnt_q != CW'(NUM_WORDS)) err_cnt_q <= err_cnt_q + CW'(1);
                if (err_cnt_q == '0) first_err_q <= idx_q;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_WR;
                        mode_q      <= mode_e'(mode);
                        seed_q      <= seed;
                        idx_q       <= '0;
                        sent_q      <= 1'b0;
                        wr_err_q    <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                ST_WR: begin
                    // First WR cycle loads address/data for the freshly updated index.
                    if (!sent_q) begin
                        awaddr_q  <= word_addr;
                        wdata_q   <= pat;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        sent_q    <= 1'b1;
                    end else begin
                        if (m_axi_awready) awvalid_q <= 1'b0;
                        if (m_axi_wready)  wvalid_q  <= 1'b0;
                        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                            state_q  <= ST_WR_RESP;
                            bready_q <= 1'b1;
                            sent_q   <= 1'b0;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q        <= 1'b0;
                        wr_err_q[idx_q] <= wr_fail;
                        if (last_word) begin
                            idx_q   <= '0;
                            state_q <= ST_RD;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_WR;
                        end
                    end
                end
                ST_RD: begin
                    if (!sent_q) begin
                        araddr_q  <= word_addr;
                        arvalid_q <= 1'b1;
                        sent_q    <= 1'b1;
                    end else if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        sent_q    <= 1'b0;
                        state_q   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (last_word) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_q == '0) && !new_err;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_RD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_selftest_master.sv
// Directed bench for axil_selftest_master against a small AXI4-Lite memory slave.
module tb_axil_selftest_master;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, pass;
    logic [2:0]  err_cnt;
    logic [1:0]  first_err_idx;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 ACLK = ~ACLK;

    axil_selftest_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Memory slave with optional random ready/response delays and fault injection
    int          rnd_en = 0;
    int          bad_b_word = -1;
    int          bad_r_word = -1;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_dly = 0, r_dly = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_dup = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic        bvalid_r = 1'b0, rvalid_r = 1'b0;
    logic [1:0]  bresp_r = 2'b00, rresp_r = 2'b00;
    logic [31:0] aw_buf = '0, w_buf = '0, ar_buf = '0, rdata_r = '0;
    logic [31:0] mem [4];
    logic [31:0] wlog_a [64];
    logic [31:0] wlog_d [64];

    assign m_axi_awready = (aw_cnt == 0);
    assign m_axi_wready  = (w_cnt == 0);
    assign m_axi_arready = (ar_cnt == 0);
    assign m_axi_bvalid  = bvalid_r;
    assign m_axi_bresp   = bresp_r;
    assign m_axi_rvalid  = rvalid_r;
    assign m_axi_rresp   = rresp_r;
    assign m_axi_rdata   = rdata_r;

    function automatic int dly();
        return (rnd_en != 0) ? int'($urandom_range(0, 5)) : 0;
    endfunction

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_dly <= 0; r_dly <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_got) n_dup <= n_dup + 1;
                aw_got <= 1'b1; aw_buf <= m_axi_awaddr; n_aw <= n_aw + 1; aw_cnt <= dly();
            end else if (aw_cnt != 0) aw_cnt <= aw_cnt - 1;
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_got) n_dup <= n_dup + 1;
                w_got <= 1'b1; w_buf <= m_axi_wdata; n_w <= n_w + 1; w_cnt <= dly();
            end else if (w_cnt != 0) w_cnt <= w_cnt - 1;
            if (aw_got && w_got && !b_pend && !bvalid_r) begin
                b_pend <= 1'b1; b_dly <= dly();
            end
            if (b_pend) begin
                if (b_dly == 0) begin
                    bvalid_r <= 1'b1;
                    bresp_r  <= (int'(aw_buf[3:2]) == bad_b_word) ? 2'b10 : 2'b00;
                    mem[aw_buf[3:2]] <= w_buf;
                    wlog_a[n_b % 64] <= aw_buf;
                    wlog_d[n_b % 64] <= w_buf;
                    n_b <= n_b + 1;
                    aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
                end else b_dly <= b_dly - 1;
            end
            if (bvalid_r && m_axi_bready) bvalid_r <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                if (r_pend || rvalid_r) n_dup <= n_dup + 1;
                r_pend <= 1'b1; ar_buf <= m_axi_araddr; n_ar <= n_ar + 1;
                ar_cnt <= dly(); r_dly <= dly();
            end else begin
                if (ar_cnt != 0) ar_cnt <= ar_cnt - 1;
                if (r_pend && !rvalid_r) begin
                    if (r_dly == 0) begin
                        rvalid_r <= 1'b1;
                        rresp_r  <= 2'b00;
                        rdata_r  <= mem[ar_buf[3:2]] ^ ((int'(ar_buf[3:2]) == bad_r_word) ? 32'h100 : 32'h0);
                        r_pend   <= 1'b0;
                    end else r_dly <= r_dly - 1;
                end
            end
            if (rvalid_r && m_axi_rready) rvalid_r <= 1'b0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, pass, err_cnt, first_err_idx, m_axi_awvalid,
                              m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
        check({tag, "_awaddr"}, m_axi_awaddr, 64'd0);
        check({tag, "_araddr"}, m_axi_araddr, 64'd0);
        check({tag, "_wdata"}, m_axi_wdata, 64'd0);
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [31:0] s);
        @(negedge ACLK);
        start = 1'b1; mode = m; seed = s;
        @(negedge ACLK);
        start = 1'b0; mode = 2'd2; seed = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] m, input logic [31:0] s,
                                 input int inject, input logic exp_pass, input logic [2:0] exp_err,
                                 input logic [1:0] exp_first, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
        int aw0 = n_aw;
        int w0 = n_w;
        int ar0 = n_ar;
        int b0 = n_b;
        logic [31:0] ed [4];
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        pulse_start(m, s);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        if (inject != 0) begin
            repeat (3) @(negedge ACLK);
            pulse_start(2'd1, 32'h55);
        end
        wait_done(tag);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_first"}, first_err_idx, exp_first);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_naw"}, n_aw - aw0, 4);
        check({tag, "_nw"}, n_w - w0, 4);
        check({tag, "_nar"}, n_ar - ar0, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_wa%0d", tag, k), wlog_a[(b0 + k) % 64], 32'(4 * k));
            check($sformatf("%s_wd%0d", tag, k), wlog_d[(b0 + k) % 64], ed[k]);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        check("wstrb", m_axi_wstrb, 4'hF);
        check("prot", {m_axi_awprot, m_axi_arprot}, 6'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        run_and_check("incr", 2'd0, 32'd1, 0, 1'b1, 3'd0, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);

        bad_r_word = 2;
        run_and_check("walk", 2'd1, 32'h1234, 0, 1'b0, 3'd1, 2'd2, 32'd1, 32'd2, 32'd4, 32'd8);
        bad_r_word = -1;

        bad_b_word = 0; bad_r_word = 0;
        run_and_check("inv", 2'd2, 32'hFFFF_FFFF, 0, 1'b0, 3'd1, 2'd0,
                      32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        bad_b_word = -1; bad_r_word = -1;

        rnd_en = 1;
        run_and_check("rand1", 2'd0, 32'd1, 0, 1'b1, 3'd0, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        run_and_check("rand2", 2'd3, 32'd1, 0, 1'b1, 3'd0, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        rnd_en = 0;

        pulse_start(2'd0, 32'd1);
        n = 0;
        while (!(m_axi_rready === 1'b1 && m_axi_araddr === 32'h4) && n < 500) begin
            @(negedge ACLK);
            n++;
        end
        check("rst_reach_rd1", {m_axi_rready, m_axi_araddr}, {1'b1, 32'h4});
        ARESETN = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge ACLK);
        check_all_zero("rst_next");
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        check("rst_no_resume", {busy, done, m_axi_awvalid, m_axi_arvalid}, 4'd0);
        run_and_check("after_rst", 2'd0, 32'd1, 0, 1'b1, 3'd0, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);

        run_and_check("ignore", 2'd0, 32'd1, 1, 1'b1, 3'd0, 2'd0, 32'd1, 32'd2, 32'd3, 32'd4);
        run_and_check("rerun", 2'd0, 32'd5, 0, 1'b1, 3'd0, 2'd0, 32'd5, 32'd6, 32'd7, 32'd8);

        check("no_dup", n_dup, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
